// File: rtl/sdram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_responder_if
// Description : Command/address bus between an SDR SDRAM controller and the
//               sdram_responder device emulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_responder_if;
    logic        sdram_CLKE;
    logic        sdram_CSn;
    logic [2:0]  sdram_CMD;
    logic [1:0]  sdram_BA;
    logic [11:0] sdram_MUXADD;
    logic        sdram_DQM;

    modport master (
        output sdram_CLKE, sdram_CSn, sdram_CMD, sdram_BA, sdram_MUXADD, sdram_DQM
    );
    modport slave (
        input  sdram_CLKE, sdram_CSn, sdram_CMD, sdram_BA, sdram_MUXADD, sdram_DQM
    );
endinterface
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sdram_responder
// Description : Synthesizable byte-wide SDR SDRAM device emulator with init
//               tracking, per-bank timing checks and a CAS-latency read pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int T_INIT   = 100,
    parameter int T_RP     = 2,
    parameter int T_RCD    = 2,
    parameter int T_RFC    = 7,
    parameter int T_MRD    = 2
) (
    input  wire logic          clk,
    input  wire logic          RESET,
    sdram_responder_if.slave   bus,
    inout  wire       [7:0]    sdram_DQ,
    output logic               init_done,
    output logic               protocol_err,
    output logic      [3:0]    err_code,
    output logic      [15:0]   refresh_count
);

    localparam int          c_AW     = 2 + ROW_BITS + COL_BITS;
    localparam int          c_DEPTH  = 1 << c_AW;
    localparam int          c_IW     = $clog2(T_INIT + 1);
    localparam logic [c_IW-1:0] c_INIT_N = c_IW'(T_INIT);
    localparam logic [7:0]  c_RP_LD  = 8'(T_RP - 1);
    localparam logic [7:0]  c_RCD_LD = 8'(T_RCD - 1);
    localparam logic [7:0]  c_RFC_LD = 8'(T_RFC - 1);
    localparam logic [7:0]  c_MRD_LD = 8'(T_MRD - 1);

    localparam logic [2:0]  c_CMD_ACT = 3'b101;
    localparam logic [2:0]  c_CMD_RD  = 3'b110;
    localparam logic [2:0]  c_CMD_WR  = 3'b010;
    localparam logic [2:0]  c_CMD_PRE = 3'b001;
    localparam logic [2:0]  c_CMD_REF = 3'b100;
    localparam logic [2:0]  c_CMD_LMR = 3'b000;

    localparam logic [2:0]  c_ST_PWRUP = 3'd0;
    localparam logic [2:0]  c_ST_PRE   = 3'd1;
    localparam logic [2:0]  c_ST_REF1  = 3'd2;
    localparam logic [2:0]  c_ST_REF2  = 3'd3;
    localparam logic [2:0]  c_ST_READY = 3'd4;

    logic [2:0]          r_init_state, w_init_state_nxt;
    logic                w_init_ok;
    logic [c_IW-1:0]     r_init_cnt;
    logic [3:0]          r_bank_act;
    logic [ROW_BITS-1:0] r_bank_row [4];
    logic [7:0]          r_trcd [4];
    logic [7:0]          r_trp  [4];
    logic [7:0]          r_trfc, r_tmrd;
    logic [1:0]          r_cl;
    logic [3:0]          r_pipe_v;
    logic [7:0]          r_pipe_d [4];
    logic [7:0]          r_mem [c_DEPTH];

    logic w_en, w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_cmd;
    logic [1:0]      w_ba;
    logic            w_a10, w_any_act, w_trp_any, w_acc_ok, w_lmr_ok, w_cl_ok;
    logic [c_AW-1:0] w_addr;
    logic [10:1]     w_err;
    logic [3:0]      w_err_first;
    logic            w_mem_we, w_dq_oe;
    logic            w_unused;

    assign w_en  = bus.sdram_CLKE & ~bus.sdram_CSn;
    assign w_act = w_en & (bus.sdram_CMD == c_CMD_ACT);
    assign w_rd  = w_en & (bus.sdram_CMD == c_CMD_RD);
    assign w_wr  = w_en & (bus.sdram_CMD == c_CMD_WR);
    assign w_pre = w_en & (bus.sdram_CMD == c_CMD_PRE);
    assign w_ref = w_en & (bus.sdram_CMD == c_CMD_REF);
    assign w_lmr = w_en & (bus.sdram_CMD == c_CMD_LMR);
    assign w_cmd = w_act | w_rd | w_wr | w_pre | w_ref | w_lmr;

    assign w_ba      = bus.sdram_BA;
    assign w_a10     = bus.sdram_MUXADD[10];
    assign w_any_act = |r_bank_act;
    assign w_acc_ok  = r_bank_act[w_ba] & (r_trcd[w_ba] == 8'd0);
    assign w_cl_ok   = (bus.sdram_MUXADD[6:4] == 3'd2) | (bus.sdram_MUXADD[6:4] == 3'd3);
    assign w_lmr_ok  = w_cl_ok & (bus.sdram_MUXADD[2:0] == 3'd0);
    assign w_addr    = {w_ba, r_bank_row[w_ba], bus.sdram_MUXADD[COL_BITS-1:0]};
    assign w_unused  = ^bus.sdram_MUXADD;

    assign init_done = (r_init_state == c_ST_READY);

    // A WRITE on the bus means the controller owns DQ, so drop our drive at once.
    assign w_dq_oe  = r_pipe_v[0] & ~w_wr;
    assign sdram_DQ = w_dq_oe ? r_pipe_d[0] : 8'bz;
    assign w_mem_we = w_wr & w_acc_ok & ~bus.sdram_DQM & ~RESET;

    always_comb begin
        w_trp_any = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (r_trp[b] != 8'd0) w_trp_any = 1'b1;
        end
    end

    always_comb begin
        w_init_state_nxt = r_init_state;
        w_init_ok        = 1'b1;
        case (r_init_state)
            c_ST_PWRUP: if (w_pre & w_a10) w_init_state_nxt = c_ST_PRE;   else if (w_cmd) w_init_ok = 1'b0;
            c_ST_PRE:   if (w_ref)         w_init_state_nxt = c_ST_REF1;  else if (w_cmd) w_init_ok = 1'b0;
            c_ST_REF1:  if (w_ref)         w_init_state_nxt = c_ST_REF2;  else if (w_cmd) w_init_ok = 1'b0;
            c_ST_REF2:  if (w_lmr)         w_init_state_nxt = c_ST_READY; else if (w_cmd) w_init_ok = 1'b0;
            default:    w_init_state_nxt = c_ST_READY;
        endcase
    end

    always_comb begin
        w_err     = '0;
        w_err[1]  = ~w_init_ok;
        w_err[2]  = ((w_rd | w_wr) & ~r_bank_act[w_ba]) | ((w_ref | w_lmr) & w_any_act);
        w_err[3]  = w_act & r_bank_act[w_ba];
        w_err[4]  = (w_act & (r_trp[w_ba] != 8'd0)) | ((w_ref | w_lmr) & w_trp_any);
        w_err[5]  = (w_rd | w_wr) & r_bank_act[w_ba] & (r_trcd[w_ba] != 8'd0);
        w_err[6]  = w_cmd & (r_trfc != 8'd0);
        w_err[7]  = w_cmd & (r_tmrd != 8'd0);
        w_err[8]  = w_lmr & ~w_lmr_ok;
        w_err[9]  = w_wr & r_pipe_v[0];
        w_err[10] = w_cmd & (r_init_cnt < c_INIT_N);
        // Scan downwards so the lowest active code is the one left standing.
        w_err_first = 4'd0;
        for (int i = 10; i >= 1; i--) begin
            if (w_err[i]) w_err_first = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_init_state  <= c_ST_PWRUP;
            r_init_cnt    <= '0;
            r_bank_act    <= '0;
            r_trfc        <= '0;
            r_tmrd        <= '0;
            r_cl          <= 2'd2;
            r_pipe_v      <= '0;
            protocol_err  <= 1'b0;
            err_code      <= '0;
            refresh_count <= '0;
            for (int b = 0; b < 4; b++) begin
                r_bank_row[b] <= '0;
                r_trcd[b]     <= '0;
                r_trp[b]      <= '0;
                r_pipe_d[b]   <= '0;
            end
        end else if (bus.sdram_CLKE) begin
            r_init_state <= w_init_state_nxt;
            if (r_init_cnt != c_INIT_N) r_init_cnt <= r_init_cnt + 1'b1;
            if (r_trfc != 8'd0) r_trfc <= r_trfc - 8'd1;
            if (r_tmrd != 8'd0) r_tmrd <= r_tmrd - 8'd1;
            for (int b = 0; b < 4; b++) begin
                if (r_trcd[b] != 8'd0) r_trcd[b] <= r_trcd[b] - 8'd1;
                if (r_trp[b]  != 8'd0) r_trp[b]  <= r_trp[b]  - 8'd1;
            end

            if (w_act & ~r_bank_act[w_ba]) begin
                r_bank_act[w_ba] <= 1'b1;
                r_bank_row[w_ba] <= bus.sdram_MUXADD[ROW_BITS-1:0];
                r_trcd[w_ba]     <= c_RCD_LD;
            end
            if (w_pre) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_a10 || (w_ba == 2'(b))) begin
                        r_bank_act[b] <= 1'b0;
                        r_trp[b]      <= c_RP_LD;
                    end
                end
            end
            if (w_ref) begin
                r_trfc        <= c_RFC_LD;
                refresh_count <= refresh_count + 16'd1;
            end
            if (w_lmr) begin
                r_tmrd <= c_MRD_LD;
                if (w_cl_ok) r_cl <= bus.sdram_MUXADD[5:4];
            end

            // Slot CL lands on DQ exactly CL enabled edges after the READ.
            for (int i = 0; i < 3; i++) begin
                r_pipe_v[i] <= r_pipe_v[i+1];
                r_pipe_d[i] <= r_pipe_d[i+1];
            end
            r_pipe_v[3] <= 1'b0;
            if (w_rd & w_acc_ok) begin
                r_pipe_v[r_cl] <= ~bus.sdram_DQM;
                r_pipe_d[r_cl] <= r_mem[w_addr];
            end

            if ((|w_err) & ~protocol_err) begin
                protocol_err <= 1'b1;
                err_code     <= w_err_first;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_addr] <= sdram_DQ;
    end

endmodule
`default_nettype wire
